// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: latches a config word, strobes the PLL, waits out
// a blanking window, then requires a run of locked cycles before declaring success.
module pll_reconfig_seq #(
    parameter int PLL_DATA_WIDTH = 16,
    parameter int BLANK_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [PLL_DATA_WIDTH-1:0] req_data,
    output logic                      req_ready,
    output logic [PLL_DATA_WIDTH-1:0] pll_data,
    output logic                      pll_trigger,
    input  logic                      pll_locked,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      stable,
    output logic [1:0]                retry_count
);

    localparam int BW = (BLANK_CYCLES  > 1) ? $clog2(BLANK_CYCLES)  : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;

    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that sees lock is the first locked cycle, so SETTLE
    // finishes when its counter is about to reach SETTLE_CYCLES-1.
    localparam logic [SW-1:0] SETTLE_STOP = SW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [SW-1:0] SETTLE_MAX  = {SW{1'b1}};

    typedef enum logic [2:0] {
        IDLE, TRIGGER, BLANK, WAIT_LOCK, SETTLE, DONE, FAIL
    } state_t;

    state_t state, state_n;

    logic [BW-1:0]             blank_cnt;
    logic [SW-1:0]             settle_cnt;
    logic [TW-1:0]             to_cnt;
    logic [1:0]                retry_q;
    logic [PLL_DATA_WIDTH-1:0] data_q;
    logic                      stable_q;
    logic                      timeout, retry_ok, settle_hit, retrying;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        timeout    = (to_cnt == TO_LAST);
        retry_ok   = (32'(retry_q) < MAX_RETRIES);
        settle_hit = pll_locked && (settle_cnt == SETTLE_STOP);
        case (state)
            IDLE:      if (req_valid) state_n = TRIGGER;
            TRIGGER:   state_n = BLANK;
            BLANK:     if (blank_cnt == BLANK_LAST) state_n = WAIT_LOCK;
            WAIT_LOCK: begin
                if (timeout)         state_n = retry_ok ? TRIGGER : FAIL;
                else if (pll_locked) state_n = SETTLE;
            end
            SETTLE: begin
                // completion beats a coincident timeout
                if (settle_hit)       state_n = DONE;
                else if (timeout)     state_n = retry_ok ? TRIGGER : FAIL;
                else if (!pll_locked) state_n = WAIT_LOCK;
            end
            DONE:      state_n = IDLE;
            FAIL:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        retrying = (state == WAIT_LOCK || state == SETTLE) && (state_n == TRIGGER);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blank_cnt  <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            retry_q    <= '0;
            data_q     <= '0;
            stable_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                data_q   <= req_data;
                retry_q  <= '0;
                stable_q <= 1'b0;
            end else if (state == IDLE && !pll_locked) begin
                stable_q <= 1'b0;
            end else if (state == DONE) begin
                stable_q <= 1'b1;
            end

            if (state != BLANK)              blank_cnt <= '0;
            else if (blank_cnt != BLANK_LAST) blank_cnt <= blank_cnt + 1'b1;

            if (state == BLANK)
                to_cnt <= '0;
            else if ((state == WAIT_LOCK || state == SETTLE) && to_cnt != TO_LAST)
                to_cnt <= to_cnt + 1'b1;

            if (state == WAIT_LOCK)
                settle_cnt <= '0;
            else if (state == SETTLE && pll_locked && settle_cnt != SETTLE_MAX)
                settle_cnt <= settle_cnt + 1'b1;

            if (retrying && retry_q != 2'b11) retry_q <= retry_q + 1'b1;
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign pll_trigger = (state == TRIGGER);
    assign done        = (state == DONE);
    assign error       = (state == FAIL);
    assign pll_data    = data_q;
    assign stable      = stable_q;
    assign retry_count = retry_q;

endmodule
